// File: rtl/jtag_reg_master_pkg.sv
// jtag_reg_master_pkg
//   Shared constants for the debug-side register-file JTAG initiator:
//   FSM state encodings and the response error codes returned on rsp_err_o.
//   No ports; imported by jtag_reg_master.
package jtag_reg_master_pkg;

   // FSM state encodings (also visible on jtag_reg_master.dbg_state_o)
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_HALT_WAIT = 3'd1;
   localparam logic [2:0] ST_ACCESS    = 3'd2;
   localparam logic [2:0] ST_VERIFY    = 3'd3;
   localparam logic [2:0] ST_RESP      = 3'd4;

   // Response error codes
   localparam logic [1:0] JRM_ERR_OK      = 2'd0;
   localparam logic [1:0] JRM_ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] JRM_ERR_VERIFY  = 2'd2;

endpackage

// File: rtl/jtag_reg_master.sv
// jtag_reg_master
//   Debug-side initiator for the register file's JTAG port. Takes one
//   read/write command at a time, requests a core halt, performs the access,
//   verifies writes by reading the register back, then returns a response.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   req_valid_i/ready_o command handshake; req_write_i/addr_i/wdata_i payload
//   keep_halt_i         keep halt_req_o asserted after the response handshake
//   rsp_valid_o/ready_i response handshake; rsp_rdata_o/rsp_err_o payload
//   halt_req_o/halted_i core halt request / halted status
//   jtag_*_o/_i         register file JTAG port (read data is combinational)
//   dbg_state_o         current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_* is ignored while req_ready_o is low; rsp_valid_o stays
// high with stable rdata/err until rsp_ready_i is seen, and rsp_ready_i is
// ignored while rsp_valid_o is low.
module jtag_reg_master
   import jtag_reg_master_pkg::*;
#(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32,
   parameter int HALT_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   input  logic              keep_halt_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic [1:0]        rsp_err_o,
   output logic              halt_req_o,
   input  logic              halted_i,
   output logic              jtag_w_enable_o,
   output logic [ADDR_W-1:0] jtag_addr_o,
   output logic [DATA_W-1:0] jtag_w_data_o,
   input  logic [DATA_W-1:0] jtag_r_data_i,
   output logic [2:0]        dbg_state_o
);

   localparam int CNT_W = (HALT_TIMEOUT < 1) ? 1 : $clog2(HALT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(HALT_TIMEOUT);

   logic [2:0]        state_q, state_d;
   logic              ready_q, ready_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              halt_q, halt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        err_q, err_d;

   // Saturating increment: the counter never wraps back to zero.
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      halt_d  = halt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            // ready_q gates acceptance so nothing is taken while in reset
            // or in the first cycle after it.
            if (req_valid_i && ready_q) begin
               write_d = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               halt_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_HALT_WAIT;
            end
         end
         ST_HALT_WAIT: begin
            if (halted_i) begin
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= TMO) begin
                  rdata_d = '0;
                  err_d   = JRM_ERR_TIMEOUT;
                  state_d = ST_RESP;
               end
            end
         end
         ST_ACCESS: begin
            if (!write_q) begin
               rdata_d = jtag_r_data_i;
               err_d   = JRM_ERR_OK;
               state_d = ST_RESP;
            end else if (addr_q == '0) begin
               // x0 is hard-wired to zero: skip the strobe and the readback.
               rdata_d = '0;
               err_d   = JRM_ERR_OK;
               state_d = ST_RESP;
            end else begin
               state_d = ST_VERIFY;
            end
         end
         ST_VERIFY: begin
            rdata_d = jtag_r_data_i;
            err_d   = (jtag_r_data_i != wdata_q) ? JRM_ERR_VERIFY : JRM_ERR_OK;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               halt_d  = keep_halt_i;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ready_d = (state_d == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         halt_q  <= 1'b0;
         rdata_q <= '0;
         err_q   <= JRM_ERR_OK;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         halt_q  <= halt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // The strobe is also gated by halted_i: if the core leaves halt in the
   // access cycle the write is dropped and the readback reports the mismatch.
   assign jtag_w_enable_o = (state_q == ST_ACCESS) && write_q &&
                            (addr_q != '0) && halted_i;
   assign jtag_addr_o     = addr_q;
   assign jtag_w_data_o   = wdata_q;
   assign req_ready_o     = ready_q;
   assign rsp_valid_o     = (state_q == ST_RESP);
   assign rsp_rdata_o     = rdata_q;
   assign rsp_err_o       = err_q;
   assign halt_req_o      = halt_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_jtag_reg_master.sv
module tb_jtag_reg_master;

   localparam int TMO = 8;
   localparam logic [31:0] MASK = 32'h0000_FF00;

   logic        clk;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [4:0]  req_addr_i;
   logic [31:0] req_wdata_i;
   logic        keep_halt_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_err_o;
   logic        halt_req_o;
   logic        halted_i;
   logic        jtag_w_enable_o;
   logic [4:0]  jtag_addr_o;
   logic [31:0] jtag_w_data_o;
   logic [31:0] jtag_r_data_i;
   logic [2:0]  dbg_state_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   jtag_reg_master #(.ADDR_W(5), .DATA_W(32), .HALT_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_write_i(req_write_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .keep_halt_i(keep_halt_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .halt_req_o(halt_req_o), .halted_i(halted_i),
      .jtag_w_enable_o(jtag_w_enable_o), .jtag_addr_o(jtag_addr_o),
      .jtag_w_data_o(jtag_w_data_o), .jtag_r_data_i(jtag_r_data_i),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: act=running req=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: act=0x%0h req=0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Power-on contents of the register file.
   function automatic logic [31:0] base_val(input int i);
      if (i == 0) return 32'h0;
      if (i == 5) return 32'hDEAD_BEEF;
      return 32'h0101_0101 * i;
   endfunction

   // ---------------- register file environment ----------------
   bit [31:0] env_wr [32];
   bit        env_wr_v [32];
   bit        corrupt = 1'b0;
   int        strobe_cnt = 0;

   always_comb begin
      jtag_r_data_i = 32'h0;
      if (jtag_addr_o != 5'd0)
         jtag_r_data_i = (env_wr_v[jtag_addr_o] ? env_wr[jtag_addr_o]
                                                : base_val(int'(jtag_addr_o)))
                         ^ (corrupt ? MASK : 32'h0);
   end

   always @(posedge clk) begin
      if (jtag_w_enable_o) begin
         env_wr[jtag_addr_o]   <= jtag_w_data_o;
         env_wr_v[jtag_addr_o] <= 1'b1;
         strobe_cnt            <= strobe_cnt + 1;
      end
   end

   // ---------------- behavioural model + compare ----------------
   // Transaction-level prediction: on accept in cycle A the model fixes the
   // strobe cycle, response cycle and response payload from the command and
   // the halt status; afterwards it checks every cycle.
   bit [31:0] m_rf [32];
   bit        m_rf_v [32];
   bit        m_ready = 0, m_busy = 0, m_halt = 0, m_wake = 0;
   int        m_rsp_at = 0, m_stb_at = -1;
   logic [31:0] m_rdata = 0, m_stb_data = 0;
   logic [4:0]  m_stb_addr = 0;
   logic [1:0]  m_err = 0;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      return m_rf_v[a] ? m_rf[a] : base_val(int'(a));
   endfunction

   always @(negedge clk) begin
      bit exp_rsp, exp_stb;
      if (!rst_n) begin
         chk("rst_req_ready", req_ready_o, 0);
         chk("rst_rsp_valid", rsp_valid_o, 0);
         chk("rst_halt_req", halt_req_o, 0);
         chk("rst_w_enable", jtag_w_enable_o, 0);
         chk("rst_addr", jtag_addr_o, 0);
         chk("rst_w_data", jtag_w_data_o, 0);
         chk("rst_rdata", rsp_rdata_o, 0);
         chk("rst_err", rsp_err_o, 0);
         m_busy = 0; m_ready = 0; m_halt = 0; m_wake = 1; m_stb_at = -1;
      end else begin
         exp_rsp = m_busy && (cyc >= m_rsp_at);
         exp_stb = m_busy && (cyc == m_stb_at);
         chk("req_ready", req_ready_o, m_ready);
         chk("halt_req", halt_req_o, m_halt);
         chk("rsp_valid", rsp_valid_o, exp_rsp);
         chk("w_enable", jtag_w_enable_o, exp_stb);
         if (exp_stb) begin
            chk("stb_addr", jtag_addr_o, m_stb_addr);
            chk("stb_data", jtag_w_data_o, m_stb_data);
         end
         if (exp_rsp) begin
            chk("rsp_rdata", rsp_rdata_o, m_rdata);
            chk("rsp_err", rsp_err_o, m_err);
         end
         if (m_wake) begin
            m_ready = 1; m_wake = 0;
         end else if (m_ready && req_valid_i) begin
            m_ready = 0; m_busy = 1; m_halt = 1; m_stb_at = -1;
            if (!halted_i) begin
               m_rsp_at = cyc + 1 + TMO; m_rdata = 0; m_err = 2'd1;
            end else if (!req_write_i) begin
               m_rsp_at = cyc + 3; m_rdata = m_read(req_addr_i); m_err = 2'd0;
            end else if (req_addr_i == 5'd0) begin
               m_rsp_at = cyc + 3; m_rdata = 0; m_err = 2'd0;
            end else begin
               m_stb_at   = cyc + 2;
               m_stb_addr = req_addr_i;
               m_stb_data = req_wdata_i;
               m_rsp_at   = cyc + 4;
               m_rf[req_addr_i]   = req_wdata_i;
               m_rf_v[req_addr_i] = 1'b1;
               m_rdata = corrupt ? (req_wdata_i ^ MASK) : req_wdata_i;
               m_err   = corrupt ? 2'd2 : 2'd0;
            end
         end else if (exp_rsp && rsp_ready_i) begin
            m_busy = 0; m_ready = 1; m_halt = keep_halt_i;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_cmd(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic k, input int stall,
                         output logic [31:0] rd, output logic [1:0] er,
                         output int lat, output int acc_c, output int rsp_c);
      int n;
      rd = '0; er = '0; lat = -1; acc_c = -1; rsp_c = -1;
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = d;
      keep_halt_i = k; rsp_ready_i = (stall == 0);
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!req_ready_o && n < 20);
      chk("accept_seen", req_ready_o, 1);
      if (!req_ready_o) begin
         req_valid_i = 1'b0;
         return;
      end
      acc_c = cyc;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      req_write_i = 1'($urandom_range(0, 1));
      req_addr_i  = 5'($urandom_range(0, 31));
      req_wdata_i = $urandom;
      n = 0;
      while (!rsp_valid_o && n < 40) begin
         @(negedge clk); n++;
      end
      chk("rsp_seen", rsp_valid_o, 1);
      if (!rsp_valid_o) return;
      rd = rsp_rdata_o; er = rsp_err_o; rsp_c = cyc; lat = rsp_c - acc_c;
      if (stall > 0) begin
         repeat (stall) @(posedge clk);
         #1 rsp_ready_i = 1'b1;
         @(negedge clk);
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [31:0] rd;
      logic [1:0]  er;
      int lat, acc_c, rsp_c, prev_rsp, s0, n;

      rst_n = 1'b1; req_valid_i = 0; req_write_i = 0; req_addr_i = 0;
      req_wdata_i = 0; keep_halt_i = 0; rsp_ready_i = 1; halted_i = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ready_after_reset", req_ready_o, 1);

      // read x5
      do_cmd(0, 5'd5, 32'h0, 0, 0, rd, er, lat, acc_c, rsp_c);
      chk("rd5_data", rd, 32'hDEAD_BEEF);
      chk("rd5_err", er, 0);
      chk("rd5_latency", lat, 3);

      // write x7 and read it back
      s0 = strobe_cnt;
      do_cmd(1, 5'd7, 32'h1234_5678, 0, 0, rd, er, lat, acc_c, rsp_c);
      chk("wr7_err", er, 0);
      chk("wr7_rdata", rd, 32'h1234_5678);
      chk("wr7_latency", lat, 4);
      chk("wr7_one_strobe", strobe_cnt - s0, 1);
      do_cmd(0, 5'd7, 32'h0, 0, 0, rd, er, lat, acc_c, rsp_c);
      chk("rd7_data", rd, 32'h1234_5678);

      // write x0: no strobe
      s0 = strobe_cnt;
      do_cmd(1, 5'd0, 32'hFFFF_FFFF, 0, 0, rd, er, lat, acc_c, rsp_c);
      chk("wr0_rdata", rd, 0);
      chk("wr0_err", er, 0);
      chk("wr0_latency", lat, 3);
      chk("wr0_no_strobe", strobe_cnt - s0, 0);

      // short sweep of reads
      for (int i = 1; i <= 4; i++) begin
         do_cmd(0, 5'(i), 32'h0, 0, 0, rd, er, lat, acc_c, rsp_c);
         chk("sweep_rd", rd, 32'h0101_0101 * i);
      end

      // response held under back-pressure
      do_cmd(0, 5'd5, 32'h0, 0, 3, rd, er, lat, acc_c, rsp_c);
      chk("stall_rd5", rd, 32'hDEAD_BEEF);

      // halt timeout (read, then write with no strobe)
      halted_i = 1'b0;
      do_cmd(0, 5'd5, 32'h0, 0, 0, rd, er, lat, acc_c, rsp_c);
      chk("tmo_rd_err", er, 1);
      chk("tmo_rd_rdata", rd, 0);
      chk("tmo_rd_latency", lat, TMO + 1);
      s0 = strobe_cnt;
      do_cmd(1, 5'd4, 32'hCAFE_F00D, 0, 0, rd, er, lat, acc_c, rsp_c);
      chk("tmo_wr_err", er, 1);
      chk("tmo_wr_no_strobe", strobe_cnt - s0, 0);
      halted_i = 1'b1;

      // verify mismatch: readback corrupted
      corrupt = 1'b1;
      do_cmd(1, 5'd3, 32'hA5A5_A5A5, 0, 0, rd, er, lat, acc_c, rsp_c);
      corrupt = 1'b0;
      chk("vfy_err", er, 2);
      chk("vfy_rdata", rd, 32'hA5A5_5AA5);
      chk("vfy_latency", lat, 4);

      // reset during HALT_WAIT aborts a write silently
      s0 = strobe_cnt;
      halted_i = 1'b0;
      @(posedge clk); #1;
      req_valid_i = 1; req_write_i = 1; req_addr_i = 5'd9;
      req_wdata_i = 32'h0BAD_F00D; keep_halt_i = 0;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!req_ready_o && n < 20);
      chk("abort_accept", req_ready_o, 1);
      @(posedge clk); #1 req_valid_i = 0;
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_halt_req", halt_req_o, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; halted_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_strobe", strobe_cnt - s0, 0);
      chk("abort_x9_kept", env_wr_v[9], 0);

      // keep_halt: two back-to-back reads, then release
      do_cmd(0, 5'd5, 32'h0, 1, 0, rd, er, lat, acc_c, rsp_c);
      chk("keep1_rd", rd, 32'hDEAD_BEEF);
      prev_rsp = rsp_c;
      do_cmd(0, 5'd7, 32'h0, 1, 0, rd, er, lat, acc_c, rsp_c);
      chk("keep2_rd", rd, 32'h1234_5678);
      chk("keep2_b2b_accept", acc_c, prev_rsp + 1);
      chk("keep2_latency", lat, 3);
      @(negedge clk);
      chk("keep_halt_held", halt_req_o, 1);
      do_cmd(0, 5'd3, 32'h0, 0, 0, rd, er, lat, acc_c, rsp_c);
      chk("keep3_rd", rd, 32'hA5A5_A5A5);
      @(negedge clk);
      chk("halt_released", halt_req_o, 0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
